// File: rtl/instruction_sequencer_pkg.sv
// Shared types and helpers for the instruction sequencer.
// Opcode map, decode classes, state encoding and length rules.
package seq_pkg;

    localparam int WORD = 64;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ALU   = 4'h1,
        OP_ALUI  = 4'h2,
        OP_LOAD  = 4'h3,
        OP_STORE = 4'h4,
        OP_JMP   = 4'hC,
        OP_BZ    = 4'hD,
        OP_HALT  = 4'hE
    } op_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ISSUE,
        CL_JMP,
        CL_BZ,
        CL_HALT,
        CL_ILL
    } cls_e;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_Z,
        ST_STOP
    } seq_state_e;

    function automatic logic op_has_imm(input logic [3:0] op);
        case (op)
            OP_ALUI, OP_LOAD, OP_STORE, OP_JMP, OP_BZ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] op_len(input logic [3:0] op);
        return op_has_imm(op) ? 4'd6 : 4'd2;
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: class, byte length, immediate
// presence and legality for one 4-bit opcode.
module instr_decode
    import seq_pkg::*;
(
    input  logic [3:0] op,
    output cls_e       cls,
    output logic [3:0] len,
    output logic       has_imm,
    output logic       legal
);

    always_comb begin
        has_imm = op_has_imm(op);
        len     = op_len(op);
        legal   = 1'b1;
        cls     = CL_ILL;
        case (op)
            OP_NOP:  cls = CL_NOP;
            OP_ALU, OP_ALUI, OP_LOAD, OP_STORE: cls = CL_ISSUE;
            OP_JMP:  cls = CL_JMP;
            OP_BZ:   cls = CL_BZ;
            OP_HALT: cls = CL_HALT;
            default: begin
                cls   = CL_ILL;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// PC owner and decode/issue stage behind the instruction fetcher.
// Issues ops over valid/ready, resolves jumps/branches, tracks halt.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [WORD-1:0] pc,
    input  logic            f_ready,
    input  logic [15:0]     f_ins,
    input  logic [31:0]     f_imm,
    output logic            x_valid,
    input  logic            x_ready,
    output logic [3:0]      x_op,
    output logic [3:0]      x_rd,
    output logic [3:0]      x_rs,
    output logic [3:0]      x_fn,
    output logic [31:0]     x_imm,
    output logic [WORD-1:0] x_pc,
    input  logic            x_idle,
    input  logic            z_flag,
    output logic            halted,
    output logic            illegal,
    output logic [31:0]     retired
);

    seq_state_e      state_q, state_d;
    logic [WORD-1:0] pc_q, pc_d;
    logic [WORD-1:0] x_pc_q, x_pc_d;
    logic            x_valid_q, x_valid_d;
    logic [3:0]      x_op_q, x_op_d;
    logic [3:0]      x_rd_q, x_rd_d;
    logic [3:0]      x_rs_q, x_rs_d;
    logic [3:0]      x_fn_q, x_fn_d;
    logic [31:0]     x_imm_q, x_imm_d;
    logic [3:0]      len_q, len_d;
    logic [31:0]     br_imm_q, br_imm_d;
    logic            halted_q, halted_d;
    logic            illegal_q, illegal_d;
    logic [31:0]     retired_q, retired_d;

    logic [WORD-1:0] target;
    logic            fault;
    logic            retire;

    cls_e            dec_cls;
    logic [3:0]      dec_len;
    logic            dec_has_imm;
    logic            dec_legal;

    instr_decode u_dec (
        .op      (f_ins[15:12]),
        .cls     (dec_cls),
        .len     (dec_len),
        .has_imm (dec_has_imm),
        .legal   (dec_legal)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        x_pc_d    = x_pc_q;
        x_valid_d = x_valid_q;
        x_op_d    = x_op_q;
        x_rd_d    = x_rd_q;
        x_rs_d    = x_rs_q;
        x_fn_d    = x_fn_q;
        x_imm_d   = x_imm_q;
        len_d     = len_q;
        br_imm_d  = br_imm_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        target    = '0;
        fault     = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            // Fetcher output lags a new pc by one edge; skip that cycle.
            ST_SETTLE: state_d = ST_FETCH;

            ST_FETCH: begin
                if (f_ready) begin
                    unique case (dec_cls)
                        CL_NOP: begin
                            pc_d    = pc_q + 64'd2;
                            retire  = 1'b1;
                            state_d = ST_SETTLE;
                        end
                        CL_ISSUE: begin
                            x_op_d    = f_ins[15:12];
                            x_rd_d    = f_ins[11:8];
                            x_rs_d    = f_ins[7:4];
                            x_fn_d    = f_ins[3:0];
                            x_imm_d   = dec_has_imm ? f_imm : 32'h0;
                            x_pc_d    = pc_q;
                            len_d     = dec_len;
                            x_valid_d = 1'b1;
                            state_d   = ST_ISSUE;
                        end
                        CL_JMP: begin
                            target = {32'h0, f_imm};
                            if (target[0]) begin
                                fault = 1'b1;
                            end else begin
                                pc_d    = target;
                                retire  = 1'b1;
                                state_d = ST_SETTLE;
                            end
                        end
                        CL_BZ: begin
                            br_imm_d = f_imm;
                            state_d  = ST_WAIT_Z;
                        end
                        CL_HALT: begin
                            retire   = 1'b1;
                            halted_d = 1'b1;
                            state_d  = ST_STOP;
                        end
                        default: fault = 1'b1;
                    endcase
                    if (!dec_legal) fault = 1'b1;
                end
            end

            ST_ISSUE: begin
                if (x_valid_q && x_ready) begin
                    x_valid_d = 1'b0;
                    pc_d      = pc_q + {60'h0, len_q};
                    retire    = 1'b1;
                    state_d   = ST_SETTLE;
                end
            end

            ST_WAIT_Z: begin
                if (x_idle) begin
                    if (z_flag) begin
                        target = pc_q + {{32{br_imm_q[31]}}, br_imm_q};
                    end else begin
                        target = pc_q + 64'd6;
                    end
                    if (target[0]) begin
                        fault = 1'b1;
                    end else begin
                        pc_d    = target;
                        retire  = 1'b1;
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_STOP: state_d = ST_STOP;

            default: state_d = ST_STOP;
        endcase

        retired_d = retired_q + {31'h0, retire};

        if (fault) begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_STOP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SETTLE;
            pc_q      <= RESET_PC;
            x_pc_q    <= '0;
            x_valid_q <= 1'b0;
            x_op_q    <= '0;
            x_rd_q    <= '0;
            x_rs_q    <= '0;
            x_fn_q    <= '0;
            x_imm_q   <= '0;
            len_q     <= '0;
            br_imm_q  <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            x_pc_q    <= x_pc_d;
            x_valid_q <= x_valid_d;
            x_op_q    <= x_op_d;
            x_rd_q    <= x_rd_d;
            x_rs_q    <= x_rs_d;
            x_fn_q    <= x_fn_d;
            x_imm_q   <= x_imm_d;
            len_q     <= len_d;
            br_imm_q  <= br_imm_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign pc      = pc_q;
    assign x_valid = x_valid_q;
    assign x_op    = x_op_q;
    assign x_rd    = x_rd_q;
    assign x_rs    = x_rs_q;
    assign x_fn    = x_fn_q;
    assign x_imm   = x_imm_q;
    assign x_pc    = x_pc_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule
